nv_nvdla_cdp_rdma_reg_consumer: RTL and testbench
=================================================

// Module: nv_nvdla_cdp_rdma_reg_consumer
// PURPOSE
//  Consumer side of the CDP RDMA ping-pong register-group handshake. Tracks op_en of
//  register groups D0/D1, owns the consumer pointer, and presents per-group status
//  (IDLE/RUNNING/PENDING) to the single-register file. Drives the datapath op_en/op_load
//  and retires a group on the datapath done pulse.
// PARAMETERS
//  DONE_GAP  1  cycles reg2dp_op_en is forced low after done before next group launches (1..15)
// PORTS
//  nvdla_core_clk    in   1  core clock
//  nvdla_core_rstn   in   1  async active-low reset
//  op_en_trigger_0   in   1  1-cycle pulse: CSB wrote op_en=1 to group D0
//  op_en_trigger_1   in   1  1-cycle pulse: CSB wrote op_en=1 to group D1
//  dp2reg_done       in   1  1-cycle pulse: datapath finished current op
//  consumer          out  1  group currently owned by datapath (0=D0, 1=D1)
//  status_0          out  2  D0 status: 0 IDLE, 1 RUNNING, 2 PENDING (3 never driven)
//  status_1          out  2  D1 status, same encoding
//  reg2dp_op_en      out  1  registered enable to datapath
//  op_load           out  1  1-cycle pulse on each 0->1 of reg2dp_op_en
//  done_err          out  1  sticky spurious-done flag (CDP_RDMA_DONE_ERR_EN only)
// BEHAVIOUR
//  Reset: consumer=0, status_0=status_1=0, reg2dp_op_en=0, op_load=0, gap_cnt=0, done_err=0,
//   op_en_g=0. All outputs are flops. Reset mid-operation drops every group to IDLE at once.
//  op_en_g (g=0,1): set by op_en_trigger_g; cleared by dp2reg_done when consumer==g and
//   reg2dp_op_en==1. Same-cycle clear and trigger on g: set wins (group re-armed).
//   Trigger while op_en_g already 1: ignored.
//  consumer: toggles on accepted done (dp2reg_done & reg2dp_op_en); otherwise holds.
//  Status (registered from next-state values, visible the cycle after the event):
//   !op_en_g -> IDLE; op_en_g & consumer==g -> RUNNING; op_en_g & consumer!=g -> PENDING.
//  Gap counter: on accepted done, gap_cnt<=DONE_GAP; decrements to 0 each cycle.
//  reg2dp_op_en next = op_en[consumer_next] & (gap_cnt_next==0) & ~accepted_done.
//   Trigger on consumer group while IDLE: reg2dp_op_en=1 one cycle after trigger
//   (latency 1); op_load pulses the same cycle.
//   After done: reg2dp_op_en low for exactly DONE_GAP cycles, then rises if the other group
//   is PENDING (latency DONE_GAP+1 from done to op_load).
//  dp2reg_done with reg2dp_op_en=0 (spurious, incl. during gap): ignored, no state change.
//  Both triggers in one cycle: both armed; consumer group runs, other PENDING.
//  Consumer wrap: 1 -> 0 by toggle; no other pointer arithmetic.
// CONFIGURATION
//  CDP_RDMA_DONE_ERR_EN defined: done_err sets on spurious done, stays 1 until reset.
//  Undefined: done_err tied 0, no flop generated; all other behaviour identical.
// TESTING
//  1 reset, trig0 @c5 -> c6: reg2dp_op_en=1, op_load=1 (1 cyc), status_0=1, status_1=0
//  2 D0 running, trig1 @c10 -> status_1=2; done @c20 -> c21 consumer=1, status_0=0,
//    status_1=1, op_en low; DONE_GAP=1 -> op_load @c22
//  3 DONE_GAP=4, only D0 armed, done -> consumer=1, both IDLE, op_en stays 0; trig0 later
//    -> status_0=2 (PENDING), op_en stays 0 until D1 armed and done
//  4 consumer=0, done and trig0 same cycle -> status_0=2, consumer=1
//  5 done with op_en=0 -> no change; with CDP_RDMA_DONE_ERR_EN done_err=1 sticky
//  6 rstn low mid-op (both groups armed) -> all outputs reset same cycle; rise -> idle

Source files
------------

// File: rtl/nv_nvdla_cdp_rdma_reg_consumer.sv
// Purpose  : consumer side of the CDP RDMA ping-pong register-group handshake (D0/D1).
// Latency  : trigger on the consumer group -> reg2dp_op_en/op_load 1 cycle later;
//            accepted done -> next op_load DONE_GAP+1 cycles later.
// Backpress: none; the datapath paces groups with dp2reg_done, spurious dones are ignored.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn  core clock, async active-low reset
//   op_en_trigger_0/1                 1-cycle pulse, CSB wrote op_en=1 to group D0/D1
//   dp2reg_done                       1-cycle pulse, datapath finished the current op
//   consumer                          group owned by the datapath (0=D0, 1=D1)
//   status_0/1                        0 IDLE, 1 RUNNING, 2 PENDING
//   reg2dp_op_en / op_load            registered enable and its rising-edge pulse
//   done_err                          sticky spurious-done flag
// Build option: define CDP_RDMA_DONE_ERR_EN to generate the done_err flop; otherwise
// done_err is tied low.
`timescale 1ns/1ps
module nv_nvdla_cdp_rdma_reg_consumer #(
  parameter int DONE_GAP = 1
) (
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rstn,
  input  logic       op_en_trigger_0,
  input  logic       op_en_trigger_1,
  input  logic       dp2reg_done,
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic       reg2dp_op_en,
  output logic       op_load,
  output logic       done_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [3:0] GAP_INIT   = 4'(DONE_GAP);

  logic [1:0] op_en_q, op_en_d;
  logic       consumer_q, consumer_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [1:0] status_0_q, status_0_d;
  logic [1:0] status_1_q, status_1_d;
  logic       dp_op_en_q, dp_op_en_d;
  logic       op_load_q, op_load_d;
  logic       accepted_done;

  // A done only counts while the datapath is actually enabled.
  assign accepted_done = dp2reg_done & dp_op_en_q;

  function automatic logic [1:0] grp_status(input logic armed, input logic owned);
    if (!armed)     return ST_IDLE;
    else if (owned) return ST_RUNNING;
    else            return ST_PENDING;
  endfunction

  always_comb begin
    op_en_d = op_en_q;
    // Retire first so a same-cycle trigger re-arms the group.
    if (accepted_done) op_en_d[consumer_q] = 1'b0;
    if (op_en_trigger_0) op_en_d[0] = 1'b1;
    if (op_en_trigger_1) op_en_d[1] = 1'b1;

    consumer_d = consumer_q ^ accepted_done;

    if (accepted_done)        gap_cnt_d = GAP_INIT;
    else if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 4'd1;
    else                      gap_cnt_d = gap_cnt_q;

    dp_op_en_d = op_en_d[consumer_d] & (gap_cnt_d == '0) & ~accepted_done;
    op_load_d  = dp_op_en_d & ~dp_op_en_q;

    status_0_d = grp_status(op_en_d[0], consumer_d == 1'b0);
    status_1_d = grp_status(op_en_d[1], consumer_d == 1'b1);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_q    <= '0;
      consumer_q <= 1'b0;
      gap_cnt_q  <= '0;
      status_0_q <= ST_IDLE;
      status_1_q <= ST_IDLE;
      dp_op_en_q <= 1'b0;
      op_load_q  <= 1'b0;
    end else begin
      op_en_q    <= op_en_d;
      consumer_q <= consumer_d;
      gap_cnt_q  <= gap_cnt_d;
      status_0_q <= status_0_d;
      status_1_q <= status_1_d;
      dp_op_en_q <= dp_op_en_d;
      op_load_q  <= op_load_d;
    end
  end

`ifdef CDP_RDMA_DONE_ERR_EN
  logic done_err_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)                 done_err_q <= 1'b0;
    else if (dp2reg_done & ~dp_op_en_q)   done_err_q <= 1'b1;
  end

  assign done_err = done_err_q;
`else
  assign done_err = 1'b0;
`endif

  assign consumer     = consumer_q;
  assign status_0     = status_0_q;
  assign status_1     = status_1_q;
  assign reg2dp_op_en = dp_op_en_q;
  assign op_load      = op_load_q;

endmodule

// File: tb/tb_nv_nvdla_cdp_rdma_reg_consumer.sv
`timescale 1ns/1ps
module tb_nv_nvdla_cdp_rdma_reg_consumer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic trig0 = 1'b0;
  logic trig1 = 1'b0;
  logic done = 1'b0;

  logic       cons_w [2];
  logic [1:0] st0_w  [2];
  logic [1:0] st1_w  [2];
  logic       en_w   [2];
  logic       load_w [2];
  logic       err_w  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nv_nvdla_cdp_rdma_reg_consumer #(.DONE_GAP(1)) dut_g1 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .op_en_trigger_0(trig0), .op_en_trigger_1(trig1), .dp2reg_done(done),
    .consumer(cons_w[0]), .status_0(st0_w[0]), .status_1(st1_w[0]),
    .reg2dp_op_en(en_w[0]), .op_load(load_w[0]), .done_err(err_w[0])
  );

  nv_nvdla_cdp_rdma_reg_consumer #(.DONE_GAP(4)) dut_g4 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .op_en_trigger_0(trig0), .op_en_trigger_1(trig1), .dp2reg_done(done),
    .consumer(cons_w[1]), .status_0(st0_w[1]), .status_1(st1_w[1]),
    .reg2dp_op_en(en_w[1]), .op_load(load_w[1]), .done_err(err_w[1])
  );

  // Behavioural reference: per-instance view of which groups are armed, who owns the
  // datapath, how many quiet cycles remain, and whether the datapath is enabled.
  int gaps [2] = '{1, 4};
  bit m_armed [2][2];
  bit m_cons  [2];
  int m_quiet [2];
  bit m_en    [2];
  bit m_load  [2];
  bit m_err   [2];

  function automatic void model_reset(int k);
    m_armed[k][0] = 0; m_armed[k][1] = 0;
    m_cons[k] = 0; m_quiet[k] = 0; m_en[k] = 0; m_load[k] = 0; m_err[k] = 0;
  endfunction

  function automatic void model_step(int k, bit t0, bit t1, bit d);
    bit finished;
    bit was_en;
    finished = d && m_en[k];
    was_en   = m_en[k];
    if (d && !m_en[k]) m_err[k] = 1;
    if (finished) begin
      m_armed[k][m_cons[k]] = 0;
      m_cons[k]  = !m_cons[k];
      m_quiet[k] = gaps[k];
    end else if (m_quiet[k] > 0) begin
      m_quiet[k] = m_quiet[k] - 1;
    end
    if (t0) m_armed[k][0] = 1;
    if (t1) m_armed[k][1] = 1;
    m_en[k]   = m_armed[k][m_cons[k]] && (m_quiet[k] == 0) && !finished;
    m_load[k] = m_en[k] && !was_en;
  endfunction

  function automatic logic [7:0] m_status(int k, int g);
    if (!m_armed[k][g]) return 8'd0;
    if (int'(m_cons[k]) == g) return 8'd1;
    return 8'd2;
  endfunction

  function automatic logic [7:0] m_err_exp(int k);
`ifdef CDP_RDMA_DONE_ERR_EN
    return {7'd0, m_err[k]};
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("g%0d consumer", gaps[k]), {7'd0, cons_w[k]}, {7'd0, m_cons[k]});
      chk($sformatf("g%0d status_0", gaps[k]), {6'd0, st0_w[k]}, m_status(k, 0));
      chk($sformatf("g%0d status_1", gaps[k]), {6'd0, st1_w[k]}, m_status(k, 1));
      chk($sformatf("g%0d op_en", gaps[k]), {7'd0, en_w[k]}, {7'd0, m_en[k]});
      chk($sformatf("g%0d op_load", gaps[k]), {7'd0, load_w[k]}, {7'd0, m_load[k]});
      chk($sformatf("g%0d done_err", gaps[k]), {7'd0, err_w[k]}, m_err_exp(k));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s g%0d outputs", tag, gaps[k]),
          {cons_w[k], st0_w[k], st1_w[k], en_w[k], load_w[k], err_w[k]}, 8'd0);
    end
  endtask

  // Drive inputs for one cycle, advance the model at the edge, check just after it.
  task automatic cycle(input bit t0, input bit t1, input bit d);
    trig0 = t0; trig1 = t1; done = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rstn) model_step(k, t0, t1, d);
      else      model_reset(k);
    end
    #1;
    trig0 = 0; trig1 = 0; done = 0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) model_reset(k);
    @(posedge clk); #1;
    check_zero("reset");
    idle(2);
    rstn = 1;
    idle(3);

    // Launch D0 from idle: one-cycle latency, single op_load pulse.
    cycle(1, 0, 0);
    chk("launch op_en", {7'd0, en_w[0]}, 8'd1);
    chk("launch op_load", {7'd0, load_w[0]}, 8'd1);
    chk("launch status_0", {6'd0, st0_w[0]}, 8'd1);
    chk("launch status_1", {6'd0, st1_w[0]}, 8'd0);
    cycle(0, 0, 0);
    chk("op_load one cycle", {7'd0, load_w[0]}, 8'd0);
    idle(3);

    // D1 queued behind D0, then D0 retires.
    cycle(0, 1, 0);
    chk("d1 pending", {6'd0, st1_w[0]}, 8'd2);
    idle(8);
    cycle(0, 0, 1);
    chk("done consumer", {7'd0, cons_w[0]}, 8'd1);
    chk("done status_0", {6'd0, st0_w[0]}, 8'd0);
    chk("done status_1", {6'd0, st1_w[0]}, 8'd1);
    chk("done op_en low", {7'd0, en_w[0]}, 8'd0);
    cycle(0, 0, 0);
    chk("gap1 op_load", {7'd0, load_w[0]}, 8'd1);
    idle(6);

    // D1 retires with nothing queued: both idle, enable stays low.
    cycle(0, 0, 1);
    chk("wrap consumer", {7'd0, cons_w[0]}, 8'd0);
    idle(6);
    chk("idle op_en", {7'd0, en_w[1]}, 8'd0);

    // Spurious done: no state change.
    cycle(0, 0, 1);
    chk("spurious consumer", {7'd0, cons_w[0]}, 8'd0);
    idle(2);

    // Done and re-trigger of the running group in the same cycle.
    cycle(1, 0, 0);
    idle(6);
    cycle(1, 0, 1);
    chk("rearm status_0", {6'd0, st0_w[0]}, 8'd2);
    chk("rearm consumer", {7'd0, cons_w[0]}, 8'd1);
    idle(3);
    cycle(0, 1, 0);
    idle(8);

    // Both triggers together, then reset while both are armed.
    cycle(0, 0, 1);
    idle(6);
    cycle(1, 1, 0);
    idle(2);
    rstn = 0;
    #1;
    check_zero("async reset");
    idle(2);
    rstn = 1;
    idle(2);
    check_zero("post reset idle");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
